// File: rtl/axi3_burst_mem_responder.sv
// AXI3 burst memory responder: independent read/write engines over a word-addressed array.
// Optional define AXI_MEM_BP_STALL_EN adds LFSR-driven backpressure on the handshakes.
module axi3_burst_mem_responder #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_ID_WIDTH   = 6,
  parameter logic [63:0] MEM_BASE_ADDR      = 64'd0,
  parameter int          MEM_ELS            = 4096
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [3:0]                      s_axi_awlen,
  input  logic [2:0]                      s_axi_awsize,
  input  logic [1:0]                      s_axi_awburst,
  input  logic [1:0]                      s_axi_awlock,
  input  logic [3:0]                      s_axi_awcache,
  input  logic [2:0]                      s_axi_awprot,
  input  logic [3:0]                      s_axi_awqos,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_wid,
  input  logic                            s_axi_wlast,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [3:0]                      s_axi_arlen,
  input  logic [2:0]                      s_axi_arsize,
  input  logic [1:0]                      s_axi_arburst,
  input  logic [1:0]                      s_axi_arlock,
  input  logic [3:0]                      s_axi_arcache,
  input  logic [2:0]                      s_axi_arprot,
  input  logic [3:0]                      s_axi_arqos,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rlast,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [1:0]                      o_dbg_wstate,
  output logic                            o_dbg_rstate
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // source never drops valid or alters its payload until that transfer occurs.
  localparam int DW      = C_S_AXI_DATA_WIDTH;
  localparam int AW      = C_S_AXI_ADDR_WIDTH;
  localparam int IW      = C_S_AXI_ID_WIDTH;
  localparam int C_LSB   = $clog2(DW / 8);
  localparam int C_MEMAW = $clog2(MEM_ELS);
  localparam logic [AW-1:0] C_MEM_ELS = AW'(MEM_ELS);
  localparam logic [AW-1:0] C_BASE    = MEM_BASE_ADDR[AW-1:0];
  localparam logic [1:0] S_W_IDLE = 2'd0;
  localparam logic [1:0] S_W_DATA = 2'd1;
  localparam logic [1:0] S_W_RESP = 2'd2;
  localparam logic       S_R_IDLE = 1'b0;
  localparam logic       S_R_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] mem [MEM_ELS];
  logic w_stall;

`ifdef AXI_MEM_BP_STALL_EN
  logic [7:0] r_lfsr;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_lfsr <= 8'h01;
    else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // ---------------- write engine ----------------
  logic [1:0]    r_wstate;
  logic          r_awready, r_wready, r_bvalid;
  logic [1:0]    r_bresp;
  logic [IW-1:0] r_bid;
  logic [AW-1:0] r_widx;
  logic [3:0]    r_wlen, r_wbeat;
  logic          r_wfixed, r_wbad, r_werr;
  logic          w_aw_hs, w_w_hs, w_win_range, w_wlast_beat, w_werr_next, w_mem_we;
  logic [AW-1:0] w_widx0;

  assign s_axi_awready = r_awready & ~w_stall;
  assign s_axi_wready  = r_wready & ~w_stall;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
  assign o_dbg_wstate  = r_wstate;

  assign w_aw_hs      = s_axi_awvalid & s_axi_awready;
  assign w_w_hs       = s_axi_wvalid & s_axi_wready;
  assign w_widx0      = (s_axi_awaddr - C_BASE) >> C_LSB;
  assign w_win_range  = r_widx < C_MEM_ELS;
  assign w_wlast_beat = r_wbeat == r_wlen;
  assign w_werr_next  = r_werr | ~w_win_range | (s_axi_wlast != w_wlast_beat);
  assign w_mem_we     = w_w_hs & w_win_range & ~r_wbad;

  // The final W transfer can only occur when unstalled, so bvalid starts unstalled too.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wstate  <= S_W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_widx    <= '0;
      r_wlen    <= 4'd0;
      r_wbeat   <= 4'd0;
      r_wfixed  <= 1'b0;
      r_wbad    <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        S_W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= s_axi_awid;
            r_widx    <= w_widx0;
            r_wlen    <= s_axi_awlen;
            r_wbeat   <= 4'd0;
            r_wfixed  <= s_axi_awburst == 2'b00;
            r_wbad    <= s_axi_awburst[1];
            r_werr    <= s_axi_awburst[1];
            r_wstate  <= S_W_DATA;
          end
        end
        S_W_DATA: begin
          if (w_w_hs) begin
            r_werr  <= w_werr_next;
            r_wbeat <= r_wbeat + 4'd1;
            if (!r_wfixed) r_widx <= r_widx + AW'(1);
            if (w_wlast_beat) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_werr_next ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= S_W_RESP;
            end
          end
        end
        S_W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= S_W_IDLE;
          end
        end
        default: r_wstate <= S_W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (s_axi_wstrb[b]) mem[r_widx[C_MEMAW-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  logic          r_rstate, r_arready, r_rvalid, r_rlast, r_rmore;
  logic [DW-1:0] r_rdata;
  logic [IW-1:0] r_rid;
  logic [1:0]    r_rresp;
  logic [AW-1:0] r_ridx;
  logic [3:0]    r_rlen, r_rbeat;
  logic          r_rfixed, r_rbad;
  logic          w_ar_hs, w_rfire, w_rload, w_rok;
  logic [AW-1:0] w_ridx0, w_src_idx;
  logic [3:0]    w_src_beat, w_src_len;
  logic          w_src_bad, w_src_fixed;

  assign s_axi_arready = r_arready & ~w_stall;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rid     = r_rid;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign o_dbg_rstate  = r_rstate;

  assign w_ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_rfire = r_rvalid & s_axi_rready;
  assign w_ridx0 = (s_axi_araddr - C_BASE) >> C_LSB;

  // Beat 0 comes straight from the AR channel so rvalid rises the cycle after AR.
  always_comb begin
    w_src_idx   = r_ridx;
    w_src_beat  = r_rbeat;
    w_src_len   = r_rlen;
    w_src_bad   = r_rbad;
    w_src_fixed = r_rfixed;
    if (r_rstate == S_R_IDLE) begin
      w_src_idx   = w_ridx0;
      w_src_beat  = 4'd0;
      w_src_len   = s_axi_arlen;
      w_src_bad   = s_axi_arburst[1];
      w_src_fixed = s_axi_arburst == 2'b00;
    end
  end

  assign w_rload = w_ar_hs |
                   ((r_rstate == S_R_DATA) & r_rmore & (~r_rvalid | w_rfire) & ~w_stall);
  assign w_rok   = (w_src_idx < C_MEM_ELS) & ~w_src_bad;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rstate  <= S_R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rmore   <= 1'b0;
      r_rdata   <= '0;
      r_rid     <= '0;
      r_rresp   <= RESP_OKAY;
      r_ridx    <= '0;
      r_rlen    <= 4'd0;
      r_rbeat   <= 4'd0;
      r_rfixed  <= 1'b0;
      r_rbad    <= 1'b0;
    end else begin
      case (r_rstate)
        S_R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= s_axi_arid;
            r_rlen    <= s_axi_arlen;
            r_rfixed  <= s_axi_arburst == 2'b00;
            r_rbad    <= s_axi_arburst[1];
            r_rstate  <= S_R_DATA;
          end
        end
        S_R_DATA: begin
          if (w_rfire && r_rlast) begin
            r_arready <= 1'b1;
            r_rstate  <= S_R_IDLE;
          end
        end
        default: r_rstate <= S_R_IDLE;
      endcase
      if (w_rload) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rok ? mem[w_src_idx[C_MEMAW-1:0]] : '0;
        r_rresp  <= w_rok ? RESP_OKAY : RESP_SLVERR;
        r_rlast  <= w_src_beat == w_src_len;
        r_rmore  <= w_src_beat != w_src_len;
        r_ridx   <= w_src_fixed ? w_src_idx : w_src_idx + AW'(1);
        r_rbeat  <= w_src_beat + 4'd1;
      end else if (w_rfire) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  logic w_unused_ok;
  assign w_unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                         s_axi_wid};
endmodule
